// File: rtl/mult4_ctrl.sv
// ==========================================================================
// mult4_ctrl : Moore controller sequencing a shift-add multiplier datapath.
// Option macro: MULT4_CTRL_EARLY_EXIT_EN (leave TEST for DONE once mplr_zero=1).
// Rev 1.0
// ==========================================================================
`default_nettype none

module mult4_ctrl #(
  parameter int N_BITS = 4,
  parameter int CNT_W  = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic q0,
  input  logic mplr_zero,
  output logic ld_ab,
  output logic clr_p,
  output logic add_en,
  output logic ld_p,
  output logic shift,
  output logic busy,
  output logic done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_TEST  = 3'd2,
    S_ADD   = 3'd3,
    S_SHIFT = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(N_BITS - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             w_exit_early;

`ifdef MULT4_CTRL_EARLY_EXIT_EN
  assign w_exit_early = mplr_zero;
`else
  logic unused_mplr_zero;
  assign unused_mplr_zero = mplr_zero;
  assign w_exit_early     = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ld_ab   = 1'b0;
    clr_p   = 1'b0;
    add_en  = 1'b0;
    ld_p    = 1'b0;
    shift   = 1'b0;
    busy    = 1'b1;
    done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_d = S_LOAD;
      end
      S_LOAD: begin
        ld_ab   = 1'b1;
        clr_p   = 1'b1;
        cnt_d   = '0;
        state_d = S_TEST;
      end
      S_TEST: begin
        // A zero multiplier means the partial product is already final.
        if (w_exit_early) state_d = S_DONE;
        else if (q0)      state_d = S_ADD;
        else              state_d = S_SHIFT;
      end
      S_ADD: begin
        add_en  = 1'b1;
        ld_p    = 1'b1;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        shift = 1'b1;
        if (cnt_q == C_CNT_LAST) begin
          state_d = S_DONE;
        end else begin
          cnt_d   = cnt_q + 1'b1;
          state_d = S_TEST;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        busy    = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_mult4_ctrl.sv
// ==========================================================================
// tb_mult4_ctrl : bench for mult4_ctrl with a datapath stub and trace model.
// Rev 1.0
// ==========================================================================
`default_nettype none

module tb_mult4_ctrl;

  typedef logic [6:0] ovec_t; // {ld_ab, clr_p, add_en, ld_p, shift, busy, done}

  localparam ovec_t O_LOAD  = 7'b1100010;
  localparam ovec_t O_TEST  = 7'b0000010;
  localparam ovec_t O_ADD   = 7'b0011010;
  localparam ovec_t O_SHIFT = 7'b0000110;
  localparam ovec_t O_DONE  = 7'b0000011;

`ifdef MULT4_CTRL_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic q0, mplr_zero;
  logic ld_ab, clr_p, add_en, ld_p, shift, busy, done;

  int tests = 0;
  int fails = 0;

  logic [3:0] operand = 4'd0;
  logic [3:0] mreg;
  ovec_t      exp_q[$];
  int         cyc = 0;
  int         acc = 0;
  int         adds_seen = 0;
  int         last_adds = -1;
  int         last_done_idx = -1;
  int         last_done_abs = -1;

  mult4_ctrl #(.N_BITS(4), .CNT_W(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .q0        (q0),
    .mplr_zero (mplr_zero),
    .ld_ab     (ld_ab),
    .clr_p     (clr_p),
    .add_en    (add_en),
    .ld_p      (ld_p),
    .shift     (shift),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Multiplier register of the datapath, driven by the controller's enables.
  always @(posedge clk or negedge rst) begin
    if (!rst)       mreg <= 4'd0;
    else if (ld_ab) mreg <= operand;
    else if (shift) mreg <= mreg >> 1;
  end
  assign q0        = mreg[0];
  assign mplr_zero = (mreg == 4'd0);

  // Expected per-cycle output sequence of one operation, from the operand bits.
  function automatic void build_trace(input logic [3:0] op);
    logic [3:0] m;
    exp_q.push_back(O_LOAD);
    for (int i = 0; i < 4; i++) begin
      m = op >> i;
      exp_q.push_back(O_TEST);
      if (EARLY && m == 4'd0) break;
      if (m[0]) exp_q.push_back(O_ADD);
      exp_q.push_back(O_SHIFT);
    end
    exp_q.push_back(O_DONE);
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      exp_q.delete();
    end else begin
      cyc++;
      if (exp_q.size() != 0) begin
        void'(exp_q.pop_front());
      end else if (start) begin
        build_trace(operand);
        acc       = cyc;
        adds_seen = 0;
      end
    end
  end

  always @(negedge clk) begin
    ovec_t act, expv;
    act  = {ld_ab, clr_p, add_en, ld_p, shift, busy, done};
    expv = (rst && exp_q.size() != 0) ? exp_q[0] : 7'b0;
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL outputs cyc=%0d actual=%b required=%b", cyc, act, expv);
    end
    if (act[3]) adds_seen++;
    if (act[0]) begin
      last_done_idx = cyc - acc + 1;
      last_done_abs = cyc;
      last_adds     = adds_seen;
    end
  end

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic wait_done(input string name, input int exp_idx, input int exp_adds);
    int n;
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      #1;
      n++;
      if (done) break;
    end
    check({name, "_timeout"}, (n < 40) ? 1 : 0, 1);
    check({name, "_done_cycle"}, last_done_idx, exp_idx);
    check({name, "_adds"}, last_adds, exp_adds);
  endtask

  task automatic run_op(input string name, input logic [3:0] op,
                        input int exp_idx, input int exp_adds);
    @(negedge clk);
    operand = op;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    wait_done(name, exp_idx, exp_adds);
  endtask

  initial begin
    int d1, n;
    #1;
    check("reset_outputs", int'({ld_ab, clr_p, add_en, ld_p, shift, busy, done}), 0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);

    run_op("op1011", 4'b1011, 13, 3);
    run_op("op0000", 4'b0000, EARLY ? 3 : 10, 0);
    run_op("op0001", 4'b0001, EARLY ? 6 : 11, 1);

    // start held high across two back-to-back operations
    @(negedge clk);
    operand = 4'b1111;
    start   = 1'b1;
    wait_done("op1111_a", 14, 4);
    d1 = last_done_abs;
    wait_done("op1111_b", 14, 4);
    check("b2b_done_spacing", last_done_abs - d1, 15);
    start = 1'b0;
    repeat (3) @(negedge clk);

    // reset during the first ADD
    @(negedge clk);
    operand = 4'b1011;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      #1;
      n++;
      if (ld_p) break;
    end
    check("reach_add", int'(ld_p), 1);
    #1 rst = 1'b0;
    #1;
    check("midop_reset_outputs", int'({ld_ab, clr_p, add_en, ld_p, shift, busy, done}), 0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    check("post_reset_busy", int'(busy), 0);

    run_op("op0110", 4'b0110, EARLY ? 11 : 12, 2);
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/mult4_ctrl.md
# mult4_ctrl

Multi-cycle controller for the 4-bit shift-add multiplier datapath. It sequences the datapath registers (multiplicand, multiplier, partial product, iteration count) by driving their load, clear, shift and add enables from a Moore state machine. It has a start/done handshake toward the issuing logic and reads two status bits back from the datapath. It holds no operand data itself.

## Interface
- N_BITS, 4, number of multiplier bits (iterations); legal range 1..2**CNT_W
- CNT_W, 2, width of the internal iteration counter
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-low reset
- start  input  1  request a multiply; sampled only in IDLE
- q0  input  1  LSB of the multiplier register, sampled in TEST
- mplr_zero  input  1  multiplier register is all zeros (see Configuration)
- ld_ab  output  1  load multiplicand and multiplier registers from operand bus
- clr_p  output  1  clear the partial-product register
- add_en  output  1  select adder output into the partial-product register
- ld_p  output  1  load enable of the partial-product register
- shift  output  1  shift the partial-product/multiplier pair right by one
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle completion pulse

## Operation
- States: IDLE, LOAD, TEST, ADD, SHIFT, DONE. Encoding is free.
- IDLE: all enables 0. If start=1, go to LOAD; otherwise stay.
- LOAD: ld_ab=1, clr_p=1, cnt<=0. Go to TEST.
- TEST: no enables. If q0=1, go to ADD; otherwise go to SHIFT.
- ADD: add_en=1, ld_p=1. Go to SHIFT.
- SHIFT: shift=1. If cnt==N_BITS-1, go to DONE; otherwise cnt<=cnt+1 and go to TEST.
- DONE: done=1. Go to IDLE unconditionally.
- Outputs are a pure function of state (Moore). Enables must never overlap except ld_ab/clr_p in LOAD and add_en/ld_p in ADD.
- cnt wraps only through the LOAD clear. It never increments past N_BITS-1.
- start while busy=1 is ignored and is not queued. start high during the DONE cycle is ignored; a new operation needs start=1 in an IDLE cycle.
- Reset (rst=0), at any time including mid-operation:
  - state goes to IDLE and cnt to 0 immediately;
  - every output is 0 (busy=0, done=0);
  - no partial pulse is emitted after reset is released.

## Timing
- Let edge k be the rising edge that samples start=1 in IDLE.
- LOAD is the cycle after edge k (cycle 1).
- Each iteration costs 2 cycles (TEST, SHIFT), plus 1 for ADD when q0=1.
- Total latency to done: 1 + 2·N_BITS + popcount(multiplier) + 1 cycles. done is high in the last of these cycles.
- The earliest back-to-back start is the cycle after DONE (IDLE); that gives one idle cycle between operations.
- q0 and mplr_zero are read in TEST. The datapath guarantees they reflect the register state after the preceding SHIFT or LOAD edge.

## Configuration
- MULT4_CTRL_EARLY_EXIT_EN defined: in TEST, mplr_zero=1 goes directly to DONE, and takes priority over q0. Remaining iterations are skipped; the partial product is already final.
- Not defined: mplr_zero is ignored (port remains, unconnected internally), and every operation runs all N_BITS iterations.

## Test plan
- Reset mid-operation: start, then rst=0 during the first ADD -> all outputs 0 immediately. After release, the block stays in IDLE with busy=0 until the next start.
- Multiplier 4'b1011, macro off: done pulses in cycle 13 after edge k; the ADD count is 3; the next start in the IDLE cycle is accepted.
- Multiplier 4'b0000, macro off: done in cycle 10, ld_p never asserted. Macro on: done in cycle 3 (LOAD, TEST, DONE).
- Multiplier 4'b0001, macro on: sequence LOAD, TEST, ADD, SHIFT, TEST, DONE, with done in cycle 6. Macro off: done in cycle 11.
- start held high continuously across two operations with multiplier 4'b1111: done in cycle 14, IDLE for 1 cycle, then LOAD. No start is accepted while busy=1.
- Check the enable pattern per state against Operation every cycle: no shift coincides with ld_p, and busy=1 in every non-IDLE cycle.
